// File: rtl/truth_table_pkg.sv
// ----------------------------------------------------------------------------
// truth_table_pkg
// Shared types and helpers for the truth-table characterisation stages.
//   sweep_state_t    : sweep controller states
//   tt_width(n)      : number of truth-table bits for an n-input function
//   DEFAULT_EXPECTED : truth-table code of the 0xBD reference gate
// ----------------------------------------------------------------------------
package truth_table_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } sweep_state_t;

    function automatic int tt_width(input int n);
        return 2 ** n;
    endfunction

    localparam logic [7:0] DEFAULT_EXPECTED = 8'hBD;

endpackage

// File: rtl/settle_timer.sv
// ----------------------------------------------------------------------------
// settle_timer
// Auto-reloading down-counter that marks the last cycle of a settle window.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset (count returns to 0)
//   load   : preload the counter with CYCLES-1 (start of a new window)
//   enable : count down by one per edge; reloads after reaching 0
//   expire : high during the cycle whose closing edge ends the window,
//            i.e. the edge on which the owner should capture
// ----------------------------------------------------------------------------
module settle_timer
    import truth_table_pkg::*;
#(
    parameter int CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int            CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Reloading on expiry lets back-to-back windows run without a gap cycle.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = RELOAD;
        end else if (enable) begin
            count_d = (count_q == '0) ? RELOAD : count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = enable && (count_q == '0);

endmodule

// File: rtl/truth_table_sweep.sv
// ----------------------------------------------------------------------------
// truth_table_sweep
// Walks an N_IN-input combinational function through every input vector in
// ascending order, holds each vector SETTLE_CYCLES clocks, samples the
// function output and assembles the truth-table code (bit i = output for
// vector i). The finished code is compared against EXPECTED.
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset, priority over everything
//   start       : request a sweep (accepted in IDLE, or on the DONE exit edge)
//   abort       : stop a sweep in progress at the next edge, no done pulse
//   drive       : input vector to the function (MSB -> in1, LSB -> in_N_IN)
//   sample      : function output, same clock domain
//   busy        : high while sweeping
//   done        : one-cycle pulse on normal completion
//   truth_table : captured code, bit i sampled while drive == i
//   match       : registered truth_table == EXPECTED, valid from done onward
// ----------------------------------------------------------------------------
module truth_table_sweep
    import truth_table_pkg::*;
#(
    parameter int                      N_IN          = 3,
    parameter int                      SETTLE_CYCLES = 2,
    parameter logic [(2**N_IN)-1:0]    EXPECTED      = DEFAULT_EXPECTED
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    output logic [N_IN-1:0]        drive,
    input  logic                   sample,
    output logic                   busy,
    output logic                   done,
    output logic [(2**N_IN)-1:0]   truth_table,
    output logic                   match
);

    localparam int              W    = tt_width(N_IN);
    localparam logic [N_IN-1:0] LAST = {N_IN{1'b1}};

    sweep_state_t  state_q, state_d;
    logic [N_IN-1:0] drive_q, drive_d;
    logic [W-1:0]  table_q, table_d;
    logic          match_q, match_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    logic          timer_load;
    logic          timer_en;
    logic          capture;

    settle_timer #(
        .CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .enable (timer_en),
        .expire (capture)
    );

    // Next-state logic. The DONE exit edge may accept a held start directly,
    // which gives the minimum start-to-start period of one sweep plus a cycle.
    always_comb begin
        state_d    = state_q;
        drive_d    = drive_q;
        table_d    = table_q;
        match_d    = match_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        timer_load = 1'b0;
        timer_en   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = SETTLE;
                    drive_d    = '0;
                    table_d    = '0;
                    match_d    = 1'b0;
                    busy_d     = 1'b1;
                    timer_load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    drive_d = '0;
                    match_d = 1'b0;
                end else begin
                    timer_en = 1'b1;
                    if (capture) begin
                        table_d[drive_q] = sample;
                        if (drive_q == LAST) begin
                            // Compare includes the bit captured on this edge.
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            match_d = (table_d == EXPECTED);
                        end else begin
                            drive_d = drive_q + 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                drive_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            drive_q <= '0;
            table_q <= '0;
            match_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drive_q <= drive_d;
            table_q <= table_d;
            match_q <= match_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign drive       = drive_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign truth_table = table_q;
    assign match       = match_q;

endmodule
